// File: rtl/wave_queue_param.sv
// wave_queue_param: per-wavefront instruction/PC queue with fetch slot
// reservation, in-order fill, head pop and flush-time drop tracking.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   q_vtail_incr    fetch issued, reserve one slot
//   q_wr            fetch return, write instr_pc_in into the real tail
//   q_rd            pop head entry
//   q_reset         flush: discard entries, turn reservations into drops
//   instr_pc_in     write data
//   instr_pc_out    head entry data (async read)
//   q_empty         no written entries
//   stop_fetch      occupancy incl. reservations and drops >= STOP_LEVEL
//   q_count         written entries
//   q_drop_pending  in-flight returns still to be discarded
//   q_err           one-cycle pulse after a protocol violation
module wave_queue_param #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int STOP_LEVEL = DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     q_vtail_incr,
  input  logic                     q_wr,
  input  logic                     q_rd,
  input  logic                     q_reset,
  input  logic [DATA_WIDTH-1:0]    instr_pc_in,
  output logic [DATA_WIDTH-1:0]    instr_pc_out,
  output logic                     q_empty,
  output logic                     stop_fetch,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [$clog2(DEPTH):0]   q_drop_pending,
  output logic                     q_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] vtail_q, vtail_d;
  logic [PW-1:0] drop_q, drop_d;
  logic          err_q, err_d;
  logic          we;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] resv;
  logic [PW:0]   occ;
  logic          incr_ok;
  logic          wr_drop;
  logic          wr_fill;
  logic          wr_bad;

  assign resv    = vtail_q - tail_q;
  // Extra bit so the sum of live slots and pending drops cannot wrap.
  assign occ     = {1'b0, vtail_q - head_q} + {1'b0, drop_q};
  assign incr_ok = occ < (PW+1)'(DEPTH);
  assign wr_drop = q_wr && (drop_q != '0);
  assign wr_fill = q_wr && (drop_q == '0) && (resv != '0);
  assign wr_bad  = q_wr && (drop_q == '0) && (resv == '0);

  assign q_empty        = (head_q == tail_q);
  assign q_count        = tail_q - head_q;
  assign q_drop_pending = drop_q;
  assign stop_fetch     = occ >= (PW+1)'(STOP_LEVEL);
  assign instr_pc_out   = mem_q[head_q[AW-1:0]];
  assign q_err          = err_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    vtail_d = vtail_q;
    drop_d  = drop_q;
    err_d   = 1'b0;
    we      = 1'b0;
    if (q_reset) begin
      // Outstanding reservations (after this cycle's old-stream ops)
      // become returns that must be swallowed later.
      drop_d  = PW'({1'b0, drop_q}
                  - (PW+1)'(wr_drop)
                  + {1'b0, resv}
                  + (PW+1)'(q_vtail_incr)
                  - (PW+1)'(wr_fill));
      head_d  = '0;
      tail_d  = '0;
      vtail_d = '0;
    end else begin
      if (q_vtail_incr) begin
        if (incr_ok) vtail_d = vtail_q + 1'b1;
        else         err_d   = 1'b1;
      end
      if (wr_drop) drop_d = drop_q - 1'b1;
      if (wr_fill) begin
        we     = 1'b1;
        tail_d = tail_q + 1'b1;
      end
      if (wr_bad) err_d = 1'b1;
      if (q_rd) begin
        if (!q_empty) head_d = head_q + 1'b1;
        else          err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      vtail_q <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      vtail_q <= vtail_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      if (we) mem_q[tail_q[AW-1:0]] <= instr_pc_in;
    end
  end

endmodule

// File: tb/tb_wave_queue_param.sv
// tb_wave_queue_param: directed bench for wave_queue_param, default
// instance plus a 32-bit STOP_LEVEL=6 instance driven in lockstep.
module tb_wave_queue_param;

  logic        clk = 1'b0;
  logic        rst, incr, wr, rd, flush;
  logic [63:0] din;

  logic [63:0] pc_a;
  logic        empty_a, stop_a, err_a;
  logic [3:0]  cnt_a, drop_a;

  logic [31:0] pc_b;
  logic        empty_b, stop_b, err_b;
  logic [3:0]  cnt_b, drop_b;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  wave_queue_param dut_a (
    .clk(clk), .rst(rst),
    .q_vtail_incr(incr), .q_wr(wr), .q_rd(rd), .q_reset(flush),
    .instr_pc_in(din), .instr_pc_out(pc_a),
    .q_empty(empty_a), .stop_fetch(stop_a), .q_count(cnt_a),
    .q_drop_pending(drop_a), .q_err(err_a)
  );

  wave_queue_param #(.DATA_WIDTH(32), .DEPTH(8), .STOP_LEVEL(6)) dut_b (
    .clk(clk), .rst(rst),
    .q_vtail_incr(incr), .q_wr(wr), .q_rd(rd), .q_reset(flush),
    .instr_pc_in(din[31:0]), .instr_pc_out(pc_b),
    .q_empty(empty_b), .stop_fetch(stop_b), .q_count(cnt_b),
    .q_drop_pending(drop_b), .q_err(err_b)
  );

  // Model: written entries as a queue, reservations and drops as counts.
  logic [63:0] mq[$];
  int m_resv = 0;
  int m_drop = 0;
  bit m_err  = 0;

  always @(posedge clk) begin
    int s0, r0, d0;
    bit e;
    s0 = mq.size();
    r0 = m_resv;
    d0 = m_drop;
    e  = 0;
    if (rst) begin
      mq.delete();
      m_resv = 0;
      m_drop = 0;
    end else if (flush) begin
      m_drop = d0 + r0 + int'(incr)
             - ((wr && d0 > 0) ? 1 : 0)
             - ((wr && d0 == 0 && r0 > 0) ? 1 : 0);
      mq.delete();
      m_resv = 0;
    end else begin
      if (incr) begin
        if (s0 + r0 + d0 < 8) m_resv++;
        else e = 1;
      end
      if (wr) begin
        if (d0 > 0) m_drop--;
        else if (r0 > 0) begin
          mq.push_back(din);
          m_resv--;
        end else e = 1;
      end
      if (rd) begin
        if (s0 > 0) void'(mq.pop_front());
        else e = 1;
      end
    end
    m_err = e;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int occ();
    return mq.size() + m_resv + m_drop;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("empty_a", 64'(empty_a), 64'(mq.size() == 0));
      chk("empty_b", 64'(empty_b), 64'(mq.size() == 0));
      chk("count_a", 64'(cnt_a), 64'(mq.size()));
      chk("count_b", 64'(cnt_b), 64'(mq.size()));
      chk("drop_a", 64'(drop_a), 64'(m_drop));
      chk("drop_b", 64'(drop_b), 64'(m_drop));
      chk("stop_a", 64'(stop_a), 64'(occ() >= 8));
      chk("stop_b", 64'(stop_b), 64'(occ() >= 6));
      chk("err_a", 64'(err_a), 64'(m_err));
      chk("err_b", 64'(err_b), 64'(m_err));
      if (mq.size() > 0) begin
        chk("pc_a", pc_a, mq[0]);
        chk("pc_b", 64'(pc_b), 64'(mq[0][31:0]));
      end
    end
  end

  task automatic step(bit i, bit w, bit r, bit f, logic [63:0] d);
    incr  = i;
    wr    = w;
    rd    = r;
    flush = f;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step(0, 0, 0, 0, 64'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; incr = 0; wr = 0; rd = 0; flush = 0; din = '0;
    step(0, 0, 0, 0, 64'h0);
    do_rst();
    chk_en = 1;

    // 1: reset state, fill to full, overflow incr, drain in order
    chk("rst_empty", 64'(empty_a), 64'd1);
    chk("rst_count", 64'(cnt_a), 64'd0);
    chk("rst_pc_a", pc_a, 64'h0);
    chk("rst_pc_b", 64'(pc_b), 64'h0);
    chk("rst_err", 64'(err_a), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 64'h0);
      step(0, 1, 0, 0, 64'h100 + 64'(i));
    end
    chk("full_count", 64'(cnt_a), 64'd8);
    chk("full_stop", 64'(stop_a), 64'd1);
    step(1, 0, 0, 0, 64'h0);
    chk("ovf_err", 64'(err_a), 64'd1);
    chk("ovf_count", 64'(cnt_a), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("pop_pc", pc_a, 64'h100 + 64'(i));
      step(0, 0, 1, 0, 64'h0);
    end
    chk("drained", 64'(empty_a), 64'd1);

    // 2: steady incr/wr/rd at count 3 across pointer wrap
    step(1, 0, 0, 0, 64'h0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 64'h400 + 64'(i));
    for (int i = 3; i < 23; i++) step(1, 1, 1, 0, 64'h400 + 64'(i));
    chk("wrap_count", 64'(cnt_a), 64'd3);
    chk("wrap_head", pc_a, 64'h414);
    step(0, 1, 0, 0, 64'h417);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 64'h0);
    chk("wrap_empty", 64'(empty_a), 64'd1);

    // 3: flush with 2 written and 3 reserved
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 64'h0);
    step(0, 1, 0, 0, 64'h300);
    step(0, 1, 0, 0, 64'h301);
    step(0, 0, 0, 1, 64'h0);
    chk("fl_empty", 64'(empty_a), 64'd1);
    chk("fl_drop", 64'(drop_a), 64'd3);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 64'hDEAD);
    chk("fl_drop0", 64'(drop_a), 64'd0);
    chk("fl_still_empty", 64'(empty_a), 64'd1);
    step(1, 0, 0, 0, 64'h0);
    step(0, 1, 0, 0, 64'h200);
    chk("fl_new_head", pc_a, 64'h200);
    chk("fl_new_cnt", 64'(cnt_a), 64'd1);
    step(0, 0, 1, 0, 64'h0);

    // 4: flush together with incr and wr, one reservation open
    step(1, 0, 0, 0, 64'h0);
    step(1, 1, 0, 1, 64'hBEEF);
    chk("fl4_drop", 64'(drop_a), 64'd1);
    chk("fl4_err", 64'(err_a), 64'd0);
    step(0, 1, 0, 0, 64'hDEAD);
    chk("fl4_drop0", 64'(drop_a), 64'd0);

    // 5: error pulses with no state change
    step(0, 0, 1, 0, 64'h0);
    chk("rd_empty_err", 64'(err_a), 64'd1);
    step(0, 0, 0, 0, 64'h0);
    chk("err_one_pulse", 64'(err_a), 64'd0);
    step(0, 1, 0, 0, 64'h55);
    chk("wr_nores_err", 64'(err_a), 64'd1);
    chk("wr_nores_cnt", 64'(cnt_a), 64'd0);
    step(0, 0, 0, 0, 64'h0);
    chk("err_clear", 64'(err_a), 64'd0);

    // 6: STOP_LEVEL=6 instance, entries then pending drops
    do_rst();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 64'h0);
      step(0, 1, 0, 0, 64'hA5A5_0000_0000_0600 + 64'(i));
    end
    chk("s6_stop_b", 64'(stop_b), 64'd1);
    chk("s6_stop_a", 64'(stop_a), 64'd0);
    chk("s6_pc_b", 64'(pc_b), 64'h600);
    step(0, 0, 1, 0, 64'h0);
    chk("s6_pop_stop", 64'(stop_b), 64'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 64'h0);
    step(1, 0, 0, 0, 64'h0);
    step(1, 0, 0, 1, 64'h0);
    chk("s6_drop2", 64'(drop_b), 64'd2);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 64'h0);
    chk("s6_drop_stop", 64'(stop_b), 64'd1);
    step(0, 1, 0, 0, 64'hDEAD);
    chk("s6_drop_unstop", 64'(stop_b), 64'd0);

    // reset mid-operation discards reservations and drops
    do_rst();
    chk("rst_mid_drop", 64'(drop_a), 64'd0);
    step(0, 0, 0, 0, 64'h0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
